// File: rtl/spu_sm_expu_pwl_pipe_if.sv
// Stream and configuration bundle for the softmax PWL exponent unit.
// The slave modport is the unit itself; master is the upstream/downstream/config side.
interface spu_sm_expu_pwl_pipe_if #(
    parameter int LANES  = 4,
    parameter int SEGS   = 8,
    parameter int DIN_W  = 9,
    parameter int OUT_W  = 8,
    parameter int BIAS_W = 16
);
    logic                      in_valid;
    logic                      in_ready;
    logic [LANES*DIN_W-1:0]    din;
    logic                      out_valid;
    logic                      out_ready;
    logic [LANES*OUT_W-1:0]    dout;
    logic                      cfg_we;
    logic [1:0]                cfg_sel;
    logic [$clog2(SEGS)-1:0]   cfg_idx;
    logic [BIAS_W-1:0]         cfg_wdata;
    logic                      cfg_err;
    logic                      busy;

    modport master (
        output in_valid, din, out_ready, cfg_we, cfg_sel, cfg_idx, cfg_wdata,
        input  in_ready, out_valid, dout, cfg_err, busy
    );

    modport slave (
        input  in_valid, din, out_ready, cfg_we, cfg_sel, cfg_idx, cfg_wdata,
        output in_ready, out_valid, dout, cfg_err, busy
    );
endinterface

// File: rtl/spu_sm_expu_pwl_pipe.sv
// Three-stage piecewise-linear exp approximation shared across LANES for the softmax SPU.
// p0 picks a segment, p1 forms coef*x+bias, p2 scales, rounds half-to-even and saturates.
module spu_sm_expu_pwl_pipe #(
    parameter int LANES   = 4,
    parameter int SEGS    = 8,
    parameter int DIN_W   = 9,
    parameter int COEF_W  = 8,
    parameter int BIAS_W  = 16,
    parameter int OUT_W   = 8,
    parameter int FRAC    = 6,
    parameter int SHIFT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    spu_sm_expu_pwl_pipe_if.slave bus
);
    localparam int IDX_W  = $clog2(SEGS);
    localparam int PROD_W = COEF_W + DIN_W;
    localparam int ACC_W  = ((PROD_W > BIAS_W) ? PROD_W : BIAS_W) + 1;
    localparam int V_W    = ACC_W + (1 << SHIFT_W) - 1;
    localparam logic [OUT_W-1:0] OUT_MAX = '1;

    logic signed [DIN_W-1:0]  r_bp   [SEGS-1];
    logic signed [COEF_W-1:0] r_coef [SEGS];
    logic signed [BIAS_W-1:0] r_bias [SEGS];
    logic [SHIFT_W-1:0]       r_shift;
    logic                     r_cfg_err;

    logic                     r_vld_p0, r_vld_p1, r_vld_p2;
    logic signed [DIN_W-1:0]  r_din_p0 [LANES];
    logic [IDX_W-1:0]         r_seg_p0 [LANES];
    logic signed [ACC_W-1:0]  r_acc_p1 [LANES];
    logic [LANES*OUT_W-1:0]   r_dout_p2;

    logic w_stall, w_adv, w_busy, w_cfg_ok;

    // Breakpoints need not be sorted: the lowest matching index wins.
    function automatic logic [IDX_W-1:0] seg_sel(input logic signed [DIN_W-1:0] d);
        logic [IDX_W-1:0] s;
        s = IDX_W'(SEGS-1);
        for (int i = SEGS-2; i >= 0; i--)
            if (d < r_bp[i]) s = IDX_W'(i);
        return s;
    endfunction

    function automatic logic signed [ACC_W-1:0] affine(
        input logic signed [COEF_W-1:0] c,
        input logic signed [DIN_W-1:0]  d,
        input logic signed [BIAS_W-1:0] b
    );
        logic signed [ACC_W-1:0] c_x, d_x, b_x;
        c_x = {{(ACC_W-COEF_W){c[COEF_W-1]}}, c};
        d_x = {{(ACC_W-DIN_W){d[DIN_W-1]}}, d};
        b_x = {{(ACC_W-BIAS_W){b[BIAS_W-1]}}, b};
        return c_x * d_x + b_x;
    endfunction

    // Saturation is decided on the pre-round integer so rounding can never wrap.
    function automatic logic [OUT_W-1:0] scale_round_sat(
        input logic signed [ACC_W-1:0] acc,
        input logic [SHIFT_W-1:0]      sh
    );
        logic [V_W-1:0] v;
        logic [V_W-1:0] q;
        logic           rnd;
        if (acc[ACC_W-1]) return '0;
        v   = {{(V_W-ACC_W){1'b0}}, acc} << sh;
        q   = v >> FRAC;
        rnd = v[FRAC-1] & (v[FRAC] | (|v[FRAC-2:0]));
        if (q >= V_W'(OUT_MAX)) return OUT_MAX;
        return q[OUT_W-1:0] + OUT_W'(rnd);
    endfunction

    assign w_stall  = r_vld_p2 & ~bus.out_ready;
    assign w_adv    = ~w_stall;
    assign w_busy   = r_vld_p0 | r_vld_p1 | r_vld_p2;
    assign w_cfg_ok = bus.cfg_we & ~w_busy & ~bus.in_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < SEGS-1; i++) r_bp[i] <= '0;
            for (int i = 0; i < SEGS; i++) begin
                r_coef[i] <= '0;
                r_bias[i] <= '0;
            end
            r_shift   <= '0;
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= bus.cfg_we & ~w_cfg_ok;
            if (w_cfg_ok) begin
                case (bus.cfg_sel)
                    2'd0: if (int'(bus.cfg_idx) <= SEGS-2)
                              r_bp[bus.cfg_idx] <= bus.cfg_wdata[DIN_W-1:0];
                    2'd1: r_coef[bus.cfg_idx] <= bus.cfg_wdata[COEF_W-1:0];
                    2'd2: r_bias[bus.cfg_idx] <= bus.cfg_wdata;
                    2'd3: r_shift <= bus.cfg_wdata[SHIFT_W-1:0];
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld_p0  <= 1'b0;
            r_vld_p1  <= 1'b0;
            r_vld_p2  <= 1'b0;
            r_dout_p2 <= '0;
        end else if (w_adv) begin
            r_vld_p0 <= bus.in_valid;
            r_vld_p1 <= r_vld_p0;
            r_vld_p2 <= r_vld_p1;
            // p1 -> p2: scale, round, saturate
            if (r_vld_p1)
                for (int l = 0; l < LANES; l++)
                    r_dout_p2[l*OUT_W +: OUT_W] <= scale_round_sat(r_acc_p1[l], r_shift);
        end
    end

    always_ff @(posedge clk) begin
        if (w_adv) begin
            for (int l = 0; l < LANES; l++) begin
                // input -> p0: segment select
                if (bus.in_valid) begin
                    r_din_p0[l] <= bus.din[l*DIN_W +: DIN_W];
                    r_seg_p0[l] <= seg_sel(bus.din[l*DIN_W +: DIN_W]);
                end
                // p0 -> p1: full-precision affine term
                if (r_vld_p0)
                    r_acc_p1[l] <= affine(r_coef[r_seg_p0[l]], r_din_p0[l], r_bias[r_seg_p0[l]]);
            end
        end
    end

    assign bus.in_ready  = ~w_stall;
    assign bus.out_valid = r_vld_p2;
    assign bus.dout      = r_dout_p2;
    assign bus.cfg_err   = r_cfg_err;
    assign bus.busy      = w_busy;
endmodule

// File: tb/tb_spu_sm_expu_pwl_pipe.sv
// Scoreboard bench for spu_sm_expu_pwl_pipe: directed table cases plus randomized beats
// against an integer-arithmetic reference of the PWL exponent.
module tb_spu_sm_expu_pwl_pipe;
    localparam int LANES  = 4;
    localparam int SEGS   = 8;
    localparam int DIN_W  = 9;
    localparam int OUT_W  = 8;
    localparam int BIAS_W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spu_sm_expu_pwl_pipe_if #(.LANES(LANES), .SEGS(SEGS), .DIN_W(DIN_W), .OUT_W(OUT_W),
                              .BIAS_W(BIAS_W)) bus();
    spu_sm_expu_pwl_pipe dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;
    int n_out    = 0;
    int rdy_mode = 0;
    logic [LANES*OUT_W-1:0] expq[$];

    int m_bp[SEGS-1];
    int m_coef[SEGS];
    int m_bias[SEGS];
    int m_shift;

    logic [LANES*OUT_W-1:0] mon_prev_dout = '0;
    bit                     mon_prev_stall = 1'b0;
    logic [LANES*OUT_W-1:0] mon_exp;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    function automatic int sext(input int v, input int w);
        int m;
        m = v & ((1 << w) - 1);
        if (m >= (1 << (w - 1))) m -= (1 << w);
        return m;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < SEGS-1; i++) m_bp[i] = 0;
        for (int i = 0; i < SEGS; i++) begin m_coef[i] = 0; m_bias[i] = 0; end
        m_shift = 0;
    endfunction

    function automatic void model_write(input int sel, input int idx, input int data);
        case (sel)
            0: if (idx <= SEGS-2) m_bp[idx] = sext(data, DIN_W);
            1: m_coef[idx] = sext(data, 8);
            2: m_bias[idx] = sext(data, BIAS_W);
            default: m_shift = data & 15;
        endcase
    endfunction

    // exp_pwl(x) = round_half_even((coef*x+bias) * 2^shift / 64), clamped to [0,255]
    function automatic int ref_lane(input int d);
        int s;
        longint acc, v, q, r;
        s = SEGS-1;
        for (int i = 0; i < SEGS-1; i++)
            if (d < m_bp[i]) begin s = i; break; end
        acc = longint'(m_coef[s]) * d + m_bias[s];
        if (acc < 0) return 0;
        v = acc * (longint'(1) << m_shift);
        q = v / 64;
        r = v % 64;
        if (q >= 255) return 255;
        if (r > 32 || (r == 32 && (q % 2) == 1)) q++;
        return int'(q);
    endfunction

    function automatic logic [LANES*OUT_W-1:0] ref_beat(input logic [LANES*DIN_W-1:0] d);
        logic [LANES*OUT_W-1:0] r;
        for (int l = 0; l < LANES; l++)
            r[l*OUT_W +: OUT_W] = OUT_W'(ref_lane(sext(int'(d[l*DIN_W +: DIN_W]), DIN_W)));
        return r;
    endfunction

    function automatic logic [LANES*DIN_W-1:0] pk_in(input int a, input int b, input int c, input int e);
        return {DIN_W'(e), DIN_W'(c), DIN_W'(b), DIN_W'(a)};
    endfunction

    function automatic logic [LANES*OUT_W-1:0] pk_out(input int a, input int b, input int c, input int e);
        return {OUT_W'(e), OUT_W'(c), OUT_W'(b), OUT_W'(a)};
    endfunction

    function automatic logic [LANES*DIN_W-1:0] rnd_din();
        return (LANES*DIN_W)'({$urandom(), $urandom()});
    endfunction

    task automatic send(input logic [LANES*DIN_W-1:0] d, input logic [LANES*OUT_W-1:0] req);
        int c;
        c = 0;
        bus.in_valid = 1'b1;
        bus.din      = d;
        @(negedge clk);
        while (!bus.in_ready && c < 200) begin @(negedge clk); c++; end
        if (bus.in_ready) expq.push_back(req);
        else check("send_in_ready_timeout", bus.in_ready, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_model(input logic [LANES*DIN_W-1:0] d);
        send(d, ref_beat(d));
    endtask

    task automatic cfg_write(input int sel, input int idx, input int data, input bit exp_acc,
                             input bit with_beat, input logic [LANES*DIN_W-1:0] d);
        bus.cfg_we    = 1'b1;
        bus.cfg_sel   = 2'(sel);
        bus.cfg_idx   = 3'(idx);
        bus.cfg_wdata = 16'(data);
        if (with_beat) begin bus.in_valid = 1'b1; bus.din = d; end
        @(negedge clk);
        if (with_beat) begin
            check("cfg_beat_in_ready", bus.in_ready, 1);
            expq.push_back(ref_beat(d));
        end
        @(posedge clk); #1;
        bus.cfg_we   = 1'b0;
        bus.in_valid = 1'b0;
        if (exp_acc) model_write(sel, idx, data);
        @(negedge clk);
        check("cfg_err_pulse", bus.cfg_err, exp_acc ? 0 : 1);
        @(negedge clk);
        check("cfg_err_single", bus.cfg_err, 0);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int c;
        c = 0;
        while ((expq.size() != 0 || bus.busy) && c < 1000) begin @(negedge clk); c++; end
        if (expq.size() != 0 || bus.busy) check("drain_timeout_pending", expq.size(), 0);
        @(posedge clk); #1;
    endtask

    // out_ready pattern generator: 0 always, 1 = 1,0,0,0 repeating, 2 random, 3 held low
    initial begin
        int k;
        k = 0;
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0: bus.out_ready = 1'b1;
                1: bus.out_ready = ((k % 4) == 0);
                2: bus.out_ready = 1'($urandom_range(0, 1));
                default: bus.out_ready = 1'b0;
            endcase
            k++;
        end
    end

    // Monitor: handshake rules and in-order scoreboard pop
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_prev_stall = 1'b0;
            end else begin
                check("in_ready_vs_stall", bus.in_ready, !(bus.out_valid && !bus.out_ready));
                if (mon_prev_stall) begin
                    check("stall_valid_hold", bus.out_valid, 1);
                    check("stall_dout_hold", bus.dout, mon_prev_dout);
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (expq.size() == 0) begin
                        check("unexpected_output_beats", 1, 0);
                    end else begin
                        mon_exp = expq.pop_front();
                        check("dout", bus.dout, mon_exp);
                        n_out++;
                    end
                end
                mon_prev_stall = bus.out_valid && !bus.out_ready;
                mon_prev_dout  = bus.dout;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int bps[SEGS-1];
        int c, n0;
        bps = '{-96, -80, -64, -48, -32, -16, 0};
        bus.in_valid = 1'b0; bus.din = '0;
        bus.cfg_we = 1'b0; bus.cfg_sel = '0; bus.cfg_idx = '0; bus.cfg_wdata = '0;
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_dout", bus.dout, 0);
        check("rst_cfg_err", bus.cfg_err, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_in_ready", bus.in_ready, 1);
        @(posedge clk); #1;

        // Segment select
        for (int k = 0; k < SEGS; k++) cfg_write(2, k, 64*k, 1, 0, '0);
        for (int i = 0; i < SEGS-1; i++) cfg_write(0, i, bps[i], 1, 0, '0);
        send(pk_in(-100, -96, -1, 0), pk_out(0, 1, 6, 7));
        send(pk_in(255, -50, -16, -17), pk_out(7, 3, 6, 5));
        send(pk_in(-80, -256, -64, -33), pk_out(2, 0, 3, 4));
        wait_drain();

        // Latency from acceptance to out_valid on an idle pipeline
        bus.in_valid = 1'b1; bus.din = pk_in(0, 0, 0, 0);
        @(negedge clk);
        expq.push_back(pk_out(7, 7, 7, 7));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        c = 0;
        do begin @(negedge clk); c++; end while (!bus.out_valid && c < 10);
        check("latency_cycles", c, 3);
        @(posedge clk); #1;
        wait_drain();

        // Rounding (half to even)
        cfg_write(2, 0, 96, 1, 0, '0);
        cfg_write(2, 1, 160, 1, 0, '0);
        cfg_write(2, 2, 161, 1, 0, '0);
        cfg_write(2, 3, 95, 1, 0, '0);
        cfg_write(2, 4, 63, 1, 0, '0);
        send(pk_in(-100, -90, -70, -60), pk_out(2, 2, 3, 1));
        send(pk_in(-40, -40, -100, -70), pk_out(1, 1, 2, 3));
        wait_drain();

        // Clamp and saturate
        cfg_write(1, 7, 2, 1, 0, '0);
        cfg_write(2, 7, -10, 1, 0, '0);
        cfg_write(2, 6, 16320, 1, 0, '0);
        cfg_write(1, 0, -128, 1, 0, '0);
        cfg_write(2, 0, 32767, 1, 0, '0);
        cfg_write(0, 7, 5, 1, 0, '0);
        send(pk_in(3, -1, -256, 3), pk_out(0, 255, 255, 0));
        wait_drain();
        cfg_write(1, 7, 0, 1, 0, '0);
        cfg_write(2, 7, 1024, 1, 0, '0);
        cfg_write(3, 5, 4, 1, 0, '0);
        send(pk_in(3, 3, -256, -1), pk_out(255, 255, 255, 255));
        wait_drain();
        cfg_write(3, 0, 2, 1, 0, '0);
        cfg_write(2, 7, 1000, 1, 0, '0);
        send(pk_in(3, 0, 255, -256), pk_out(62, 62, 62, 255));
        wait_drain();

        // Backpressure: 10 back-to-back beats, out_ready 1,0,0,0,...
        rdy_mode = 1;
        n0 = n_out;
        for (int i = 0; i < 10; i++) send_model(rnd_din());
        wait_drain();
        check("bp_beats_out", n_out - n0, 10);
        rdy_mode = 0;
        idle(2);

        // Config guard
        send(pk_in(3, 3, 3, 3), pk_out(62, 62, 62, 62));
        check("guard_busy_hi", bus.busy, 1);
        cfg_write(2, 7, 0, 0, 0, '0);
        wait_drain();
        send(pk_in(3, 3, 3, 3), pk_out(62, 62, 62, 62));
        wait_drain();
        cfg_write(2, 7, 0, 0, 1, pk_in(3, 3, 3, 3));
        wait_drain();
        send(pk_in(3, 3, 3, 3), pk_out(62, 62, 62, 62));
        wait_drain();
        cfg_write(2, 7, 128, 1, 0, '0);
        send(pk_in(3, 3, 3, 3), pk_out(8, 8, 8, 8));
        wait_drain();

        // Random table and random traffic
        for (int i = 0; i < SEGS; i++) cfg_write(0, i, int'($urandom_range(0, 511)), 1, 0, '0);
        for (int i = 0; i < SEGS; i++) cfg_write(1, i, int'($urandom_range(0, 255)), 1, 0, '0);
        for (int i = 0; i < SEGS; i++) cfg_write(2, i, int'($urandom_range(0, 65535)), 1, 0, '0);
        cfg_write(3, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), 1, 0, '0);
        rdy_mode = 2;
        for (int i = 0; i < 60; i++) begin
            send_model(rnd_din());
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        rdy_mode = 0;
        wait_drain();

        // Reset with three beats in flight
        rdy_mode = 3;
        idle(1);
        for (int i = 0; i < 3; i++) send_model(rnd_din());
        rst_n = 1'b0;
        expq.delete();
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        rdy_mode = 0;
        @(negedge clk);
        check("mrst_out_valid", bus.out_valid, 0);
        check("mrst_busy", bus.busy, 0);
        check("mrst_in_ready", bus.in_ready, 1);
        check("mrst_dout", bus.dout, 0);
        @(posedge clk); #1;
        idle(8);
        for (int i = 0; i < 4; i++) send(rnd_din(), pk_out(0, 0, 0, 0));
        wait_drain();

        check("queue_empty_at_end", expq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
